// File: rtl/compare_pkg.sv
// Shared types and constants for the sequential nibble comparator.
package compare_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cmp_state_t;

  localparam int unsigned NIBBLE_W = 4;

endpackage

// File: rtl/compare_seq_ctrl_if.sv
// Request/result bundle between a requesting datapath and compare_seq_ctrl.
interface compare_seq_ctrl_if #(
  parameter int unsigned WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             more;
  logic             less;
  logic             equal;

  modport master (
    output start, a, b,
    input  busy, done, more, less, equal
  );

  modport slave (
    input  start, a, b,
    output busy, done, more, less, equal
  );

endinterface

// File: rtl/compare4.sv
// Combinational 4-bit unsigned magnitude comparator used as the shared datapath.
module compare4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       MORE,
  output logic       LESS
);

  assign MORE = (a > b);
  assign LESS = (a < b);

endmodule

// File: rtl/compare_seq_ctrl.sv
// Multi-cycle magnitude comparator: walks operands one nibble per clock, MSB first,
// through a single compare4 and stops on the first differing nibble.
module compare_seq_ctrl
  import compare_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  compare_seq_ctrl_if.slave  cmp_if
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIB - 1);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
    $error("compare_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  cmp_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             more_q, more_d;
  logic             less_q, less_d;
  logic             equal_q, equal_d;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic                nib_more;
  logic                nib_less;

  // Nibble select as a shift so the index never has to be multiplied.
  always_comb begin
    nib_a = NIBBLE_W'(a_q >> {idx_q, 2'b00});
    nib_b = NIBBLE_W'(b_q >> {idx_q, 2'b00});
  end

  compare4 u_compare4 (
    .a    (nib_a),
    .b    (nib_b),
    .MORE (nib_more),
    .LESS (nib_less)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    more_d  = more_q;
    less_d  = less_q;
    equal_d = equal_q;

    unique case (state_q)
      IDLE: begin
        if (cmp_if.start) begin
          state_d = RUN;
          a_d     = cmp_if.a;
          b_d     = cmp_if.b;
          idx_d   = IDX_TOP;
          more_d  = 1'b0;
          less_d  = 1'b0;
          equal_d = 1'b0;
        end
      end
      RUN: begin
        if (nib_more || nib_less) begin
          more_d  = nib_more;
          less_d  = nib_less;
          equal_d = 1'b0;
          state_d = DONE;
        end else if (idx_q == '0) begin
          equal_d = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= IDX_TOP;
      a_q     <= '0;
      b_q     <= '0;
      more_q  <= 1'b0;
      less_q  <= 1'b0;
      equal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      more_q  <= more_d;
      less_q  <= less_d;
      equal_q <= equal_d;
    end
  end

  assign cmp_if.busy  = (state_q != IDLE);
  assign cmp_if.done  = (state_q == DONE);
  assign cmp_if.more  = more_q;
  assign cmp_if.less  = less_q;
  assign cmp_if.equal = equal_q;

endmodule

// File: tb/tb_compare_seq_ctrl.sv
// Scoreboard bench for compare_seq_ctrl: 16-bit and 4-bit instances checked against
// an arithmetic model of result and done latency.
module tb_compare_seq_ctrl;

  typedef struct {
    logic [2:0] res;   // {more, less, equal}
    int         e0;    // cycle count right after the accepting edge
    int         lat;   // edges from accept to the edge entering DONE
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  exp_t       q16[$];
  exp_t       q4[$];
  logic [2:0] last16 = 3'b000;
  logic [2:0] last4  = 3'b000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  compare_seq_ctrl_if #(.WIDTH(16)) if16 ();
  compare_seq_ctrl_if #(.WIDTH(4))  if4 ();

  compare_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk    (clk),
    .rst    (rst),
    .cmp_if (if16)
  );

  compare_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .cmp_if (if4)
  );

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic logic [2:0] model_res(int unsigned a, int unsigned b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  // Deciding nibble k (MSB = nib-1) gives done nib-k edges after accept; equal gives nib.
  function automatic int model_lat(int unsigned a, int unsigned b, int nib);
    for (int k = nib - 1; k >= 0; k--) begin
      if (((a >> (4 * k)) & 15) != ((b >> (4 * k)) & 15)) return nib - k;
    end
    return nib;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last16 = 3'b000;
    end else if (if16.done) begin
      if (q16.size() == 0) begin
        check("unexpected_done16", 32'd1, 32'd0);
      end else begin
        e = q16.pop_front();
        check("result16", {29'd0, if16.more, if16.less, if16.equal}, {29'd0, e.res});
        check("latency16", cyc, e.e0 + e.lat);
        last16 = e.res;
      end
    end else if (if16.busy) begin
      check("run_clear16", {29'd0, if16.more, if16.less, if16.equal}, 32'd0);
    end else begin
      check("hold16", {29'd0, if16.more, if16.less, if16.equal}, {29'd0, last16});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last4 = 3'b000;
    end else if (if4.done) begin
      if (q4.size() == 0) begin
        check("unexpected_done4", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        check("result4", {29'd0, if4.more, if4.less, if4.equal}, {29'd0, e.res});
        check("latency4", cyc, e.e0 + e.lat);
        last4 = e.res;
      end
    end else if (!if4.busy) begin
      check("hold4", {29'd0, if4.more, if4.less, if4.equal}, {29'd0, last4});
    end
  end

  task automatic wait_idle16();
    int g = 0;
    while (if16.busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("idle_timeout16", 32'(g), 32'd0);
  endtask

  task automatic cmp16(input logic [15:0] a, input logic [15:0] b, input bit noise);
    int g = 0;
    @(negedge clk);
    wait_idle16();
    if16.a     = a;
    if16.b     = b;
    if16.start = 1'b1;
    q16.push_back('{res: model_res(a, b), e0: cyc + 1, lat: model_lat(a, b, 4)});
    @(negedge clk);
    check("busy_after_accept16", {31'd0, if16.busy}, 32'd1);
    if16.start = 1'b0;
    while (if16.busy && g < 50) begin
      if (noise) begin
        if16.a     = 16'($urandom);
        if16.b     = 16'($urandom);
        if16.start = 1'($urandom);
      end
      @(negedge clk);
      g++;
    end
    if16.start = 1'b0;
    if (g >= 50) check("done_timeout16", 32'(g), 32'd0);
  endtask

  task automatic cmp4(input logic [3:0] a, input logic [3:0] b);
    int g = 0;
    @(negedge clk);
    while (if4.busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    if4.a     = a;
    if4.b     = b;
    if4.start = 1'b1;
    q4.push_back('{res: model_res(a, b), e0: cyc + 1, lat: 1});
    @(negedge clk);
    if4.start = 1'b0;
    while (if4.busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("done_timeout4", 32'(g), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t       first;
    logic [15:0] ra;
    logic [15:0] rb;
    int          k;

    if16.start = 1'b0;
    if16.a     = '0;
    if16.b     = '0;
    if4.start  = 1'b0;
    if4.a      = '0;
    if4.b      = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_out16", {27'd0, if16.busy, if16.done, if16.more, if16.less, if16.equal}, 32'd0);
    check("reset_out4", {27'd0, if4.busy, if4.done, if4.more, if4.less, if4.equal}, 32'd0);

    cmp16(16'h1234, 16'h1234, 1'b0);
    cmp16(16'h9000, 16'h1000, 1'b0);
    cmp16(16'h1233, 16'h1234, 1'b0);
    cmp16(16'h00F0, 16'h0000, 1'b1);
    cmp16(16'h0F00, 16'h0E00, 1'b1);

    // Held start: second request accepted on the first IDLE edge after DONE.
    @(negedge clk);
    wait_idle16();
    if16.a     = 16'h4000;
    if16.b     = 16'h5000;
    if16.start = 1'b1;
    first = '{res: 3'b010, e0: cyc + 1, lat: 1};
    q16.push_back(first);
    q16.push_back('{res: 3'b100, e0: first.e0 + first.lat + 2, lat: 3});
    @(negedge clk);
    if16.a = 16'h7770;
    if16.b = 16'h7700;
    repeat (first.lat + 2) @(negedge clk);
    if16.start = 1'b0;
    wait_idle16();

    // Reset in the middle of a compare: outputs drop at once, no done follows.
    @(negedge clk);
    if16.a     = 16'h1233;
    if16.b     = 16'h1234;
    if16.start = 1'b1;
    @(negedge clk);
    if16.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset16", {27'd0, if16.busy, if16.done, if16.more, if16.less, if16.equal},
             32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    cmp16(16'h0000, 16'h0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ra;
      if ($urandom_range(0, 3) == 0) begin
        rb = 16'($urandom);
      end else if ($urandom_range(0, 4) != 0) begin
        k  = $urandom_range(0, 3);
        rb = rb ^ (16'($urandom_range(1, 15)) << (4 * k));
      end
      cmp16(ra, rb, 1'($urandom));
    end

    for (int i = 0; i < 256; i++) begin
      cmp4(4'(i), 4'(i >> 4));
    end

    repeat (4) @(negedge clk);
    check("q16_drained", 32'(q16.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
